// File: rtl/plb_master_pkg.sv
// Shared types and constants for the single-beat PLB master.
package plb_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BACKOFF,
        S_DATA,
        S_RESP
    } state_e;

    localparam logic [3:0] PLB_SIZE_SINGLE = 4'b0000;
    localparam logic [2:0] PLB_TYPE_MEM    = 3'b000;
    localparam logic [1:0] PLB_MSIZE_32    = 2'b00;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/plb_dphase_watchdog.sv
// Data-phase watchdog: counts cycles while enabled, reloads to zero on clear,
// and flags when the count reaches LIMIT-1 (where it then holds).
module plb_dphase_watchdog
    import plb_master_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (clog2(LIMIT) < 1) ? 1 : clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/plb_single_master.sv
// Single-beat PLB v4.6 master: one local read/write command becomes one PLB
// transaction followed by a one-cycle response pulse.
module plb_single_master
    import plb_master_pkg::*;
#(
    parameter int unsigned C_MPLB_AWIDTH    = 32,
    parameter int unsigned C_MPLB_DWIDTH    = 32,
    parameter int unsigned C_MPLB_PRIORITY  = 0,
    parameter int unsigned C_DPHASE_TIMEOUT = 64,
    parameter string       C_FAMILY         = "spartan6"
) (
    input  logic                       MPLB_Clk,
    input  logic                       MPLB_Rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rnw,
    input  logic [0:C_MPLB_AWIDTH-1]   cmd_addr,
    input  logic [0:3]                 cmd_be,
    input  logic [0:C_MPLB_DWIDTH-1]   cmd_wdata,
    output logic                       rsp_valid,
    output logic [0:C_MPLB_DWIDTH-1]   rsp_rdata,
    output logic                       rsp_err,
    output logic                       M_request,
    output logic [0:1]                 M_priority,
    output logic                       M_RNW,
    output logic [0:3]                 M_BE,
    output logic [0:C_MPLB_AWIDTH-1]   M_ABus,
    output logic [0:3]                 M_size,
    output logic [0:2]                 M_type,
    output logic [0:1]                 M_MSize,
    output logic [0:C_MPLB_DWIDTH-1]   M_wrDBus,
    output logic                       M_busLock,
    output logic                       M_abort,
    output logic                       M_wrBurst,
    output logic                       M_rdBurst,
    output logic [0:31]                M_UABus,
    output logic [0:15]                M_TAttribute,
    output logic                       M_lockErr,
    input  logic                       PLB_MAddrAck,
    input  logic                       PLB_MRearbitrate,
    input  logic                       PLB_MTimeout,
    input  logic                       PLB_MRdDAck,
    input  logic                       PLB_MWrDAck,
    input  logic [0:C_MPLB_DWIDTH-1]   PLB_MRdDBus,
    input  logic                       PLB_MRdErr,
    input  logic                       PLB_MWrErr
);

    localparam logic [0:C_MPLB_AWIDTH-1] WORD_ALIGN = {{(C_MPLB_AWIDTH-2){1'b1}}, 2'b00};

    state_e                     state_q, state_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       m_request_q, m_request_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rnw_q, rnw_d;
    logic [0:3]                 be_q, be_d;
    logic [0:C_MPLB_AWIDTH-1]   abus_q, abus_d;
    logic [0:C_MPLB_DWIDTH-1]   wdata_q, wdata_d;
    logic [0:C_MPLB_DWIDTH-1]   rdata_q, rdata_d;
    logic                       err_q, err_d;
    logic                       wd_expired;
    logic                       data_ack;
    logic                       timeout_hit;

    plb_dphase_watchdog #(
        .LIMIT (C_DPHASE_TIMEOUT)
    ) u_watchdog (
        .clk     (MPLB_Clk),
        .rst_n   (MPLB_Rst_n),
        .clear   (state_q != S_DATA),
        .enable  (state_q == S_DATA),
        .expired (wd_expired)
    );

    assign data_ack    = rnw_q ? PLB_MRdDAck : PLB_MWrDAck;
    // A matching ack in the final watchdog cycle wins over the abort.
    assign timeout_hit = (state_q == S_DATA) && wd_expired && !data_ack;

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        be_d    = be_q;
        abus_d  = abus_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_REQ;
                    rnw_d   = cmd_rnw;
                    be_d    = cmd_be;
                    abus_d  = cmd_addr & WORD_ALIGN;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (PLB_MAddrAck) begin
                    if (!rnw_q && PLB_MWrDAck) begin
                        state_d = S_RESP;
                        err_d   = PLB_MWrErr;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (PLB_MTimeout) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (PLB_MRearbitrate) begin
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: state_d = S_REQ;
            S_DATA: begin
                if (rnw_q && PLB_MRdDAck) begin
                    state_d = S_RESP;
                    err_d   = PLB_MRdErr;
                    rdata_d = PLB_MRdErr ? '0 : PLB_MRdDBus;
                end else if (!rnw_q && PLB_MWrDAck) begin
                    state_d = S_RESP;
                    err_d   = PLB_MWrErr;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus qualifiers are only driven while a transaction is on the bus.
        if ((state_d == S_RESP) || (state_d == S_IDLE)) begin
            rnw_d   = 1'b0;
            be_d    = '0;
            abus_d  = '0;
            wdata_d = '0;
        end

        cmd_ready_d = (state_d == S_IDLE);
        m_request_d = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge MPLB_Clk) begin
        if (!MPLB_Rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            m_request_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rnw_q       <= 1'b0;
            be_q        <= '0;
            abus_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            m_request_q <= m_request_d;
            rsp_valid_q <= rsp_valid_d;
            rnw_q       <= rnw_d;
            be_q        <= be_d;
            abus_q      <= abus_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign M_request    = m_request_q;
    assign M_priority   = 2'(C_MPLB_PRIORITY);
    assign M_RNW        = rnw_q;
    assign M_BE         = be_q;
    assign M_ABus       = abus_q;
    assign M_wrDBus     = wdata_q;
    assign M_size       = PLB_SIZE_SINGLE;
    assign M_type       = PLB_TYPE_MEM;
    assign M_MSize      = PLB_MSIZE_32;
    assign M_busLock    = 1'b0;
    assign M_abort      = timeout_hit;
    assign M_wrBurst    = 1'b0;
    assign M_rdBurst    = 1'b0;
    assign M_UABus      = '0;
    assign M_TAttribute = '0;
    assign M_lockErr    = 1'b0;

endmodule

// File: tb/tb_plb_single_master.sv
// Directed bench for plb_single_master: stimulus pushes expected responses,
// a negedge monitor pops and compares them against rsp_valid pulses.
module tb_plb_single_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [0:31] cmd_addr = '0;
    logic [0:3]  cmd_be = '0;
    logic [0:31] cmd_wdata = '0;
    logic        rsp_valid;
    logic [0:31] rsp_rdata;
    logic        rsp_err;
    logic        M_request;
    logic [0:1]  M_priority;
    logic        M_RNW;
    logic [0:3]  M_BE;
    logic [0:31] M_ABus;
    logic [0:3]  M_size;
    logic [0:2]  M_type;
    logic [0:1]  M_MSize;
    logic [0:31] M_wrDBus;
    logic        M_busLock, M_abort, M_wrBurst, M_rdBurst, M_lockErr;
    logic [0:31] M_UABus;
    logic [0:15] M_TAttribute;
    logic        PLB_MAddrAck = 1'b0, PLB_MRearbitrate = 1'b0, PLB_MTimeout = 1'b0;
    logic        PLB_MRdDAck = 1'b0, PLB_MWrDAck = 1'b0;
    logic [0:31] PLB_MRdDBus = '0;
    logic        PLB_MRdErr = 1'b0, PLB_MWrErr = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    plb_single_master #(
        .C_MPLB_PRIORITY  (2),
        .C_DPHASE_TIMEOUT (8)
    ) dut (
        .MPLB_Clk         (clk),
        .MPLB_Rst_n       (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rnw          (cmd_rnw),
        .cmd_addr         (cmd_addr),
        .cmd_be           (cmd_be),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .M_request        (M_request),
        .M_priority       (M_priority),
        .M_RNW            (M_RNW),
        .M_BE             (M_BE),
        .M_ABus           (M_ABus),
        .M_size           (M_size),
        .M_type           (M_type),
        .M_MSize          (M_MSize),
        .M_wrDBus         (M_wrDBus),
        .M_busLock        (M_busLock),
        .M_abort          (M_abort),
        .M_wrBurst        (M_wrBurst),
        .M_rdBurst        (M_rdBurst),
        .M_UABus          (M_UABus),
        .M_TAttribute     (M_TAttribute),
        .M_lockErr        (M_lockErr),
        .PLB_MAddrAck     (PLB_MAddrAck),
        .PLB_MRearbitrate (PLB_MRearbitrate),
        .PLB_MTimeout     (PLB_MTimeout),
        .PLB_MRdDAck      (PLB_MRdDAck),
        .PLB_MWrDAck      (PLB_MWrDAck),
        .PLB_MRdDBus      (PLB_MRdDBus),
        .PLB_MRdErr       (PLB_MRdErr),
        .PLB_MWrErr       (PLB_MWrErr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        rsp_t r;
        r.rdata = rdata;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(cmd_ready), 32'd1);
    endtask

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rdata=%08h err=%0b expected none",
                             rsp_rdata, rsp_err);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_m_request", 32'(M_request), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_m_abus", M_ABus, 32'h0);
        chk("m_priority", 32'(M_priority), 32'd2);
        chk("m_consts", {M_size, M_type, M_MSize, M_busLock, M_wrBurst, M_rdBurst, M_lockErr},
            32'h0);
        rst_n = 1'b1;
        tick();

        // Read: AddrAck one cycle after request, RdDAck two cycles later
        expect_rsp(32'hDEADBEEF, 1'b0);
        issue(1'b1, 32'h1000_0013, 4'hF, 32'h0);
        chk("rd_request", 32'(M_request), 32'd1);
        chk("rd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("rd_abus_align", M_ABus, 32'h1000_0010);
        chk("rd_rnw", 32'(M_RNW), 32'd1);
        tick();
        chk("rd_request_hold", 32'(M_request), 32'd1);
        PLB_MAddrAck = 1'b1;
        tick();
        PLB_MAddrAck = 1'b0;
        chk("rd_request_drop", 32'(M_request), 32'd0);
        chk("rd_abus_data", M_ABus, 32'h1000_0010);
        tick();
        PLB_MRdDAck = 1'b1;
        PLB_MRdDBus = 32'hDEADBEEF;
        tick();
        PLB_MRdDAck = 1'b0;
        PLB_MRdDBus = 32'h0;
        chk("rd_rsp_pulse", 32'(rsp_valid), 32'd1);
        chk("rd_abus_cleared", M_ABus, 32'h0);
        wait_idle("rd_idle");

        // Write with AddrAck and WrDAck in the same cycle
        expect_rsp(32'h0, 1'b0);
        issue(1'b0, 32'hC3C00004, 4'hF, 32'h12345678);
        chk("wr_request", 32'(M_request), 32'd1);
        chk("wr_wrdbus", M_wrDBus, 32'h12345678);
        chk("wr_abus", M_ABus, 32'hC3C00004);
        chk("wr_be", 32'(M_BE), 32'hF);
        chk("wr_rnw", 32'(M_RNW), 32'd0);
        PLB_MAddrAck = 1'b1;
        PLB_MWrDAck  = 1'b1;
        tick();
        PLB_MAddrAck = 1'b0;
        PLB_MWrDAck  = 1'b0;
        chk("wr_request_drop", 32'(M_request), 32'd0);
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'd1);
        tick();
        chk("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("wr_ready_back", 32'(cmd_ready), 32'd1);

        // Rearbitrate twice, then AddrAck together with Rearbitrate
        expect_rsp(32'hCAFEF00D, 1'b0);
        issue(1'b1, 32'h0000_0020, 4'h3, 32'h0);
        for (int i = 0; i < 2; i++) begin
            PLB_MRearbitrate = 1'b1;
            tick();
            PLB_MRearbitrate = 1'b0;
            chk("rearb_backoff_low", 32'(M_request), 32'd0);
            tick();
            chk("rearb_req_again", 32'(M_request), 32'd1);
        end
        PLB_MAddrAck     = 1'b1;
        PLB_MRearbitrate = 1'b1;
        tick();
        PLB_MAddrAck     = 1'b0;
        PLB_MRearbitrate = 1'b0;
        chk("rearb_ack_wins", 32'(M_request), 32'd0);
        PLB_MWrDAck = 1'b1;
        tick();
        PLB_MWrDAck = 1'b0;
        chk("rearb_wrong_dir_ack", 32'(rsp_valid), 32'd0);
        PLB_MRdDAck = 1'b1;
        PLB_MRdDBus = 32'hCAFEF00D;
        tick();
        PLB_MRdDAck = 1'b0;
        PLB_MRdDBus = 32'h0;
        wait_idle("rearb_idle");

        // Read with no data ack: watchdog abort on the 8th data cycle
        expect_rsp(32'h0, 1'b1);
        issue(1'b1, 32'h0000_0040, 4'hF, 32'h0);
        PLB_MAddrAck = 1'b1;
        tick();
        PLB_MAddrAck = 1'b0;
        PLB_MRdDBus  = 32'h5555AAAA;
        for (int i = 1; i < 8; i++) begin
            chk("to_abort_early", 32'(M_abort), 32'd0);
            tick();
        end
        chk("to_abort_pulse", 32'(M_abort), 32'd1);
        tick();
        PLB_MRdDBus = 32'h0;
        chk("to_abort_clear", 32'(M_abort), 32'd0);
        chk("to_rsp_pulse", 32'(rsp_valid), 32'd1);
        wait_idle("to_idle");

        // Write data-phase error
        expect_rsp(32'h0, 1'b1);
        issue(1'b0, 32'h0000_0080, 4'h1, 32'hA5A5A5A5);
        PLB_MAddrAck = 1'b1;
        tick();
        PLB_MAddrAck = 1'b0;
        PLB_MWrDAck  = 1'b1;
        PLB_MWrErr   = 1'b1;
        tick();
        PLB_MWrDAck  = 1'b0;
        PLB_MWrErr   = 1'b0;
        wait_idle("wrerr_idle");

        // Address-phase timeout
        expect_rsp(32'h0, 1'b1);
        issue(1'b1, 32'h0000_00C0, 4'hF, 32'h0);
        PLB_MTimeout = 1'b1;
        tick();
        PLB_MTimeout = 1'b0;
        chk("mto_request_drop", 32'(M_request), 32'd0);
        tick();
        chk("mto_ready_back", 32'(cmd_ready), 32'd1);

        // Reset during data phase: no response
        issue(1'b1, 32'h0000_0100, 4'hF, 32'h0);
        PLB_MAddrAck = 1'b1;
        tick();
        PLB_MAddrAck = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_m_rnw", 32'(M_RNW), 32'd0);
        chk("mrst_m_abus", M_ABus, 32'h0);
        rst_n = 1'b1;
        PLB_MRdDAck = 1'b1;
        PLB_MRdDBus = 32'h11112222;
        tick();
        PLB_MRdDAck = 1'b0;
        PLB_MRdDBus = 32'h0;
        chk("mrst_stale_ack", 32'(rsp_valid), 32'd0);
        tick();
        tick();

        chk("pending_rsps", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
